// File: rtl/instr_fetch.sv
// Program store + fetch stage for the 8-bit core; optional load checksum via IFETCH_CHECKSUM_EN.
// Latency: zero-cycle combinational fetch in RUN; load_ready is registered and rises one cycle after load_start.
// Backpressure: load_ready is high only in LOAD; load_valid is ignored in every other state.
module instr_fetch #(
    parameter int          ADDR_W = 8,
    parameter logic [7:0]  BUBBLE = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        pc_in,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [7:0]        load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic [7:0]        instruction,
    output logic              core_run,
    output logic [ADDR_W:0]   load_count,
    output logic              error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_t              state, nextState;
    logic [ADDR_W-1:0]   wrAddr, nextAddr;
    logic [ADDR_W:0]     loadCount, nextCount;
    logic                errorReg, nextError;
    logic                loadReadyReg;
    logic                memWe;
    logic [7:0]          mem [0:(1<<ADDR_W)-1];
    logic                unusedPcHi;

`ifdef IFETCH_CHECKSUM_EN
    logic [7:0]          sumReg, nextSum;
`endif

    // Upper program-counter bits beyond the memory depth are deliberately dropped.
    assign unusedPcHi = ^pc_in;

    always_comb begin
        nextState = state;
        nextAddr  = wrAddr;
        nextCount = loadCount;
        nextError = errorReg;
        memWe     = 1'b0;
`ifdef IFETCH_CHECKSUM_EN
        nextSum   = sumReg;
`endif
        if (load_start) begin
            // A (re)start wins over any byte offered in the same cycle.
            nextState = LOAD;
            nextAddr  = '0;
            nextCount = '0;
            nextError = 1'b0;
`ifdef IFETCH_CHECKSUM_EN
            nextSum   = '0;
`endif
        end else if (state == LOAD && load_valid) begin
`ifdef IFETCH_CHECKSUM_EN
            if (load_last) begin
                if (loadCount != '0 && sumReg == load_data) begin
                    nextState = RUN;
                end else begin
                    nextState = ERR;
                    nextError = 1'b1;
                end
            end else begin
                memWe     = reset;
                nextAddr  = wrAddr + ADDR_W'(1);
                nextCount = loadCount + (ADDR_W+1)'(1);
                nextSum   = sumReg + load_data;
                if (wrAddr == LAST_ADDR) begin
                    nextState = ERR;
                    nextError = 1'b1;
                end
            end
`else
            memWe     = reset;
            nextAddr  = wrAddr + ADDR_W'(1);
            nextCount = loadCount + (ADDR_W+1)'(1);
            if (load_last) begin
                nextState = RUN;
            end else if (wrAddr == LAST_ADDR) begin
                nextState = ERR;
                nextError = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            wrAddr       <= '0;
            loadCount    <= '0;
            errorReg     <= 1'b0;
            loadReadyReg <= 1'b0;
        end else begin
            state        <= nextState;
            wrAddr       <= nextAddr;
            loadCount    <= nextCount;
            errorReg     <= nextError;
            loadReadyReg <= (nextState == LOAD);
        end
    end

`ifdef IFETCH_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            sumReg <= '0;
        end else begin
            sumReg <= nextSum;
        end
    end
`endif

    // Program memory survives reset; memWe is already gated by reset.
    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[wrAddr] <= load_data;
        end
    end

    assign load_ready  = loadReadyReg;
    assign core_run    = (state == RUN);
    assign instruction = (state == RUN) ? mem[pc_in[ADDR_W-1:0]] : BUBBLE;
    assign load_count  = loadCount;
    assign error       = errorReg;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: one 8-bit-address instance and one 2-bit-address instance.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       rst, ls, lv, ll;
    logic [7:0] pc, ld;
    logic       rdy, run, err;
    logic [7:0] ins;
    logic [8:0] cnt;

    logic       rst2, ls2, lv2, ll2;
    logic [7:0] pc2, ld2;
    logic       rdy2, run2, err2;
    logic [7:0] ins2;
    logic [2:0] cnt2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_fetch #(.ADDR_W(8), .BUBBLE(8'h00)) dut8 (
        .clk(clk), .reset(rst), .pc_in(pc), .load_start(ls), .load_valid(lv),
        .load_data(ld), .load_last(ll), .load_ready(rdy), .instruction(ins),
        .core_run(run), .load_count(cnt), .error(err)
    );

    instr_fetch #(.ADDR_W(2), .BUBBLE(8'h00)) dut2 (
        .clk(clk), .reset(rst2), .pc_in(pc2), .load_start(ls2), .load_valid(lv2),
        .load_data(ld2), .load_last(ll2), .load_ready(rdy2), .instruction(ins2),
        .core_run(run2), .load_count(cnt2), .error(err2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; ls = 1'b0; lv = 1'b0; ll = 1'b0; pc = 8'h00; ld = 8'h00;
        rst2 = 1'b0; ls2 = 1'b0; lv2 = 1'b0; ll2 = 1'b0; pc2 = 8'h00; ld2 = 8'h00;
        tick; tick;
        chk("rst_instr", ins, 8'h00);
        chk("rst_run", run, 1'b0);
        chk("rst_ready", rdy, 1'b0);
        chk("rst_error", err, 1'b0);
        chk("rst_count", cnt, 9'd0);
        rst = 1'b1;

`ifndef IFETCH_CHECKSUM_EN
        // load_valid pulse in IDLE must be ignored
        lv = 1'b1; ld = 8'hEE; tick;
        lv = 1'b0;
        chk("idle_valid_count", cnt, 9'd0);
        chk("idle_valid_ready", rdy, 1'b0);

        ls = 1'b1; tick;
        ls = 1'b0;
        chk("load_ready_rise", rdy, 1'b1);
        chk("load_instr_bubble", ins, 8'h00);
        lv = 1'b1; ld = 8'h41; tick;
        lv = 1'b0; ld = 8'hFF; tick;
        lv = 1'b1; ld = 8'h92; tick;
        ld = 8'hC3; ll = 1'b1; tick;
        lv = 1'b0; ll = 1'b0;
        chk("run_after_last", run, 1'b1);
        chk("count_three", cnt, 9'd3);
        chk("ready_low_run", rdy, 1'b0);
        pc = 8'd1; #1 chk("fetch_pc1", ins, 8'h92);
        pc = 8'd2; #1 chk("fetch_pc2", ins, 8'hC3);
        pc = 8'd0; #1 chk("fetch_pc0", ins, 8'h41);

        // restart from RUN, then restart mid-load with a byte discarded
        ls = 1'b1; tick;
        ls = 1'b0;
        chk("rerun_core_off", run, 1'b0);
        chk("rerun_ready", rdy, 1'b1);
        chk("rerun_count", cnt, 9'd0);
        lv = 1'b1; ld = 8'h55; tick;
        chk("one_byte_count", cnt, 9'd1);
        ls = 1'b1; ld = 8'h77; tick;
        ls = 1'b0;
        chk("restart_count", cnt, 9'd0);
        chk("restart_ready", rdy, 1'b1);
        ld = 8'hA5; ll = 1'b1; tick;
        lv = 1'b0; ll = 1'b0;
        chk("single_run", run, 1'b1);
        chk("single_count", cnt, 9'd1);
        pc = 8'd0; #1 chk("single_pc0", ins, 8'hA5);
        pc = 8'd1; #1 chk("stale_pc1", ins, 8'h92);

        // reset mid-load
        ls = 1'b1; tick;
        ls = 1'b0; lv = 1'b1; ld = 8'h11; tick;
        ld = 8'h22; tick;
        chk("partial_count", cnt, 9'd2);
        rst = 1'b0; ld = 8'h33; tick;
        rst = 1'b1; lv = 1'b0;
        chk("midreset_ready", rdy, 1'b0);
        chk("midreset_count", cnt, 9'd0);
        chk("midreset_run", run, 1'b0);
        ls = 1'b1; tick;
        ls = 1'b0; lv = 1'b1; ld = 8'h5A; ll = 1'b1; tick;
        lv = 1'b0; ll = 1'b0;
        chk("fresh_run", run, 1'b1);
        chk("fresh_count", cnt, 9'd1);
        pc = 8'd0; #1 chk("fresh_pc0", ins, 8'h5A);
        pc = 8'd1; #1 chk("partial_kept_pc1", ins, 8'h22);
        pc = 8'd2; #1 chk("no_write_in_reset", ins, 8'hC3);

        // overflow on the 4-byte instance
        rst2 = 1'b1; ls2 = 1'b1; tick;
        ls2 = 1'b0; lv2 = 1'b1;
        ld2 = 8'hA0; tick;
        ld2 = 8'hA1; tick;
        ld2 = 8'hA2; tick;
        chk("ovf_no_err_yet", err2, 1'b0);
        ld2 = 8'hA3; tick;
        chk("ovf_error", err2, 1'b1);
        chk("ovf_ready_low", rdy2, 1'b0);
        chk("ovf_count", cnt2, 3'd4);
        ld2 = 8'hA4; tick;
        lv2 = 1'b0;
        chk("ovf_fifth_ignored", cnt2, 3'd4);
        chk("ovf_bubble", ins2, 8'h00);
        tick;
        chk("ovf_core_off", run2, 1'b0);
        chk("ovf_error_sticky", err2, 1'b1);
        ls2 = 1'b1; tick;
        ls2 = 1'b0;
        chk("ovf_restart_error", err2, 1'b0);
        chk("ovf_restart_ready", rdy2, 1'b1);
        chk("ovf_restart_count", cnt2, 3'd0);
        lv2 = 1'b1; ld2 = 8'hB0; ll2 = 1'b1; tick;
        lv2 = 1'b0; ll2 = 1'b0;
        chk("small_run", run2, 1'b1);
        pc2 = 8'd0; #1 chk("small_pc0", ins2, 8'hB0);
        pc2 = 8'd3; #1 chk("small_pc3_fourth", ins2, 8'hA3);
        pc2 = 8'h41; #1 chk("small_pc_hi_ignored", ins2, 8'hA1);
`else
        ls = 1'b1; tick;
        ls = 1'b0; lv = 1'b1;
        ld = 8'h10; tick;
        ld = 8'h20; tick;
        ld = 8'h30; ll = 1'b1; tick;
        lv = 1'b0; ll = 1'b0;
        chk("csum_ok_run", run, 1'b1);
        chk("csum_ok_count", cnt, 9'd2);
        chk("csum_ok_error", err, 1'b0);
        pc = 8'd0; #1 chk("csum_pc0", ins, 8'h10);
        pc = 8'd1; #1 chk("csum_pc1", ins, 8'h20);

        ls = 1'b1; tick;
        ls = 1'b0; lv = 1'b1;
        ld = 8'h10; tick;
        ld = 8'h20; tick;
        ld = 8'h31; ll = 1'b1; tick;
        lv = 1'b0; ll = 1'b0;
        chk("csum_bad_error", err, 1'b1);
        chk("csum_bad_run", run, 1'b0);
        chk("csum_bad_bubble", ins, 8'h00);
        chk("csum_bad_ready", rdy, 1'b0);

        ls = 1'b1; tick;
        ls = 1'b0;
        chk("csum_restart_error", err, 1'b0);
        lv = 1'b1; ld = 8'h00; ll = 1'b1; tick;
        lv = 1'b0; ll = 1'b0;
        chk("csum_empty_error", err, 1'b1);
        chk("csum_empty_run", run, 1'b0);
        chk("csum_empty_count", cnt, 9'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
